// File: rtl/count_sequencer.sv
// Run controller for a WIDTH-bit up/down count between 0 and a latched limit, with prescaled step and done pulse.
// Optional COUNT_SEQ_AUTORELOAD_EN: terminal count pulses done and keeps running, reloading the start value on the next step.
module count_sequencer #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  clear_i,
  input  logic                  dir_i,
  input  logic [WIDTH-1:0]      limit_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [WIDTH-1:0]      count_o,
  output logic                  tick_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [WIDTH-1:0]      limit_q, limit_d;
  logic                  dir_q, dir_d;
  logic                  done_q, done_d;
  logic                  stepEn;

  logic [WIDTH-1:0] stepVal;
  logic [WIDTH-1:0] terminalVal;
  logic [WIDTH-1:0] startVal;

  assign stepVal     = dir_q ? (count_q - 1'b1) : (count_q + 1'b1);
  assign terminalVal = dir_q ? '0 : limit_q;
  assign startVal    = dir_q ? limit_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      presc_q    <= '0;
      prescale_q <= '0;
      limit_q    <= '0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      prescale_q <= prescale_d;
      limit_q    <= limit_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    presc_d    = presc_q;
    prescale_d = prescale_q;
    limit_d    = limit_q;
    dir_d      = dir_q;
    done_d     = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      count_d = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            dir_d      = dir_i;
            limit_d    = limit_i;
            prescale_d = prescale_i;
            presc_d    = '0;
            count_d    = dir_i ? limit_i : '0;
            state_d    = RUN;
            // A zero limit is already terminal: finish at once unless auto-reloading.
            if (limit_i == '0) begin
              count_d = '0;
`ifndef COUNT_SEQ_AUTORELOAD_EN
              state_d = DONE;
              done_d  = 1'b1;
`endif
            end
          end
        end
        RUN: begin
          if (stop_i) begin
            state_d = PAUSE;
          end else begin
            presc_d = (presc_q == prescale_q) ? '0 : presc_q + 1'b1;
            if (stepEn) begin
`ifdef COUNT_SEQ_AUTORELOAD_EN
              count_d = (count_q == terminalVal) ? startVal : stepVal;
`else
              count_d = stepVal;
`endif
              if (count_d == terminalVal) begin
                done_d = 1'b1;
`ifndef COUNT_SEQ_AUTORELOAD_EN
                state_d = DONE;
`endif
              end
            end
          end
        end
        PAUSE: begin
          if (start_i) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stepEn = (state_q == RUN) && (presc_q == prescale_q);
    busy_o = (state_q == RUN) || (state_q == PAUSE);
  end

  assign tick_o  = stepEn;
  assign count_o = count_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule
